// File: rtl/alu_operand_arbiter.sv
// rtl/alu_operand_arbiter.sv - two-requester packet arbiter for the shared ALU operand mux
// Define ALU_ARB_RR_EN for round-robin tie breaking; default build is fixed priority (req0 wins).
module alu_operand_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_last,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_last,
    output logic             req1_ready,
    output logic             mux_sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    output logic             out_last,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e           state_q;
    logic             mux_sel_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_id_q;
    logic             out_last_q;
`ifdef ALU_ARB_RR_EN
    logic             rr_ptr_q;
`endif

    logic             space;
    logic             grant_vld;
    logic             grantee;
    logic             sel_valid;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;
    logic             accept;

    assign space = !out_valid_q || out_ready;

    // An owner keeps the grant even while its valid is low, so the other side never sneaks in mid-packet.
    always_comb begin
        grant_vld = 1'b0;
        grantee   = 1'b0;
        case (state_q)
            OWN0: begin
                grant_vld = 1'b1;
                grantee   = 1'b0;
            end
            OWN1: begin
                grant_vld = 1'b1;
                grantee   = 1'b1;
            end
            default: begin
                if (req0_valid && req1_valid) begin
                    grant_vld = 1'b1;
`ifdef ALU_ARB_RR_EN
                    grantee   = !rr_ptr_q;
`else
                    grantee   = 1'b0;
`endif
                end else if (req0_valid) begin
                    grant_vld = 1'b1;
                    grantee   = 1'b0;
                end else if (req1_valid) begin
                    grant_vld = 1'b1;
                    grantee   = 1'b1;
                end
            end
        endcase
    end

    assign sel_valid = grantee ? req1_valid : req0_valid;
    assign sel_data  = grantee ? req1_data  : req0_data;
    assign sel_last  = grantee ? req1_last  : req0_last;
    assign accept    = grant_vld && sel_valid && space;

    assign req0_ready = grant_vld && !grantee && space;
    assign req1_ready = grant_vld &&  grantee && space;
    assign mux_sel    = grant_vld ? grantee : mux_sel_q;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign out_last  = out_last_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            mux_sel_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef ALU_ARB_RR_EN
            rr_ptr_q    <= 1'b1;
`endif
        end else begin
            if (grant_vld) begin
                mux_sel_q <= grantee;
            end
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= sel_data;
                out_id_q    <= grantee;
                out_last_q  <= sel_last;
                if (sel_last) begin
                    state_q <= IDLE;
`ifdef ALU_ARB_RR_EN
                    rr_ptr_q <= grantee;
`endif
                end else begin
                    state_q <= grantee ? OWN1 : OWN0;
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_arbiter.sv
// tb/tb_alu_operand_arbiter.sv - directed self-checking bench for alu_operand_arbiter
module tb_alu_operand_arbiter;

    logic        clock;
    logic        resetn;
    logic        req0_valid;
    logic [31:0] req0_data;
    logic        req0_last;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_data;
    logic        req1_last;
    logic        req1_ready;
    logic        mux_sel;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_id;
    logic        out_last;
    logic        out_ready;

    int total = 0;
    int bad   = 0;

`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    alu_operand_arbiter #(.WIDTH(32)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .mux_sel    (mux_sel),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_last   (out_last),
        .out_ready  (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic exp_id;
        resetn     = 1'b0;
        req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0;
        req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0;
        out_ready  = 1'b0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_id", out_id, 0);
        check("rst_out_last", out_last, 0);
        check("rst_mux_sel", mux_sel, 0);
        resetn = 1'b1;
        tick();

        // Ties of single-beat packets
        req0_valid = 1; req0_data = 32'hAAAA0000; req0_last = 1;
        req1_valid = 1; req1_data = 32'h5555FFFF; req1_last = 1;
        out_ready  = 1;
        for (int i = 0; i < 4; i++) begin
            exp_id = RR ? i[0] : 1'b0;
            #1;
            check("tie_mux_sel", mux_sel, exp_id);
            check("tie_req0_ready", req0_ready, !exp_id);
            check("tie_req1_ready", req1_ready, exp_id);
            tick();
            check("tie_out_id", out_id, exp_id);
            check("tie_out_data", out_data, exp_id ? 32'h5555FFFF : 32'hAAAA0000);
            check("tie_out_last", out_last, 1);
        end
        req0_valid = 0; req1_valid = 0;
        tick();
        check("drain_valid", out_valid, 0);

        // req0 3-beat packet holds off req1
        req1_valid = 1; req1_data = 32'h99; req1_last = 1;
        req0_valid = 1;
        for (int j = 0; j < 3; j++) begin
            req0_data = j + 1; req0_last = (j == 2);
            #1;
            check("pkt0_req1_ready", req1_ready, 0);
            check("pkt0_mux_sel", mux_sel, 0);
            check("pkt0_req0_ready", req0_ready, 1);
            tick();
            check("pkt0_out_data", out_data, j + 1);
            check("pkt0_out_last", out_last, j == 2);
        end
        req0_valid = 0;
        req1_data = 32'h100; req1_last = 0;
        #1;
        check("pkt1_grant_mux", mux_sel, 1);
        check("pkt1_grant_ready", req1_ready, 1);
        tick();
        check("pkt1_beat0", out_data, 32'h100);

        // Backpressure inside OWN1, req0 must stay ignored
        out_ready = 0; req1_data = 32'h101; req0_valid = 1; req0_data = 32'hDEAD; req0_last = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("bp_req1_ready", req1_ready, 0);
            check("bp_req0_ready", req0_ready, 0);
            check("bp_mux_sel", mux_sel, 1);
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, 32'h100);
        end
        out_ready = 1; req0_valid = 0;
        #1;
        check("bp_resume_ready", req1_ready, 1);
        tick();
        check("bp_beat1", out_data, 32'h101);
        req1_data = 32'h102;
        tick();
        check("bp_beat2", out_data, 32'h102);
        req1_data = 32'h103; req1_last = 1;
        tick();
        check("bp_beat3", out_data, 32'h103);
        check("bp_beat3_last", out_last, 1);
        check("bp_beat3_id", out_id, 1);
        req1_valid = 0;
        tick();
        check("bp_drain", out_valid, 0);

        // Owner 0 stalls mid-packet while req1 waits
        req0_valid = 1; req0_data = 32'h20; req0_last = 0;
        req1_valid = 1; req1_data = 32'h77; req1_last = 1;
        #1;
        check("stall_grant", mux_sel, 0);
        tick();
        check("stall_beat0", out_data, 32'h20);
        req0_valid = 0;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("stall_req1_ready", req1_ready, 0);
            check("stall_mux_sel", mux_sel, 0);
            tick();
        end
        check("stall_empty", out_valid, 0);
        req0_valid = 1; req0_data = 32'h21; req0_last = 1;
        #1;
        check("stall_resume", req0_ready, 1);
        tick();
        check("stall_beat1", out_data, 32'h21);
        check("stall_beat1_last", out_last, 1);
        check("stall_beat1_id", out_id, 0);
        #1;
        check("boundary_mux_sel", mux_sel, RR ? 1 : 0);
        check("boundary_req1_ready", req1_ready, RR ? 1 : 0);
        req0_valid = 0; req1_valid = 0;
        tick();

        // Asynchronous reset mid-packet
        out_ready = 0;
        req1_valid = 1; req1_data = 32'h30; req1_last = 0;
        tick();
        check("arst_pre_valid", out_valid, 1);
        check("arst_pre_mux", mux_sel, 1);
        req0_valid = 1; req0_data = 32'h40; req0_last = 1;
        #2 resetn = 0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_mux_sel", mux_sel, 0);
        check("arst_out_data", out_data, 0);
        #2 resetn = 1;
        #1;
        check("arst_tie_req0", req0_ready, 1);
        check("arst_tie_req1", req1_ready, 0);
        tick();
        check("arst_out_id", out_id, 0);
        check("arst_out_data2", out_data, 32'h40);
        req1_valid = 0;

        // 8-beat stream from req0
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            req0_data = 32'h10 + i; req0_last = (i == 7);
            tick();
            check("stream_valid", out_valid, 1);
            check("stream_data", out_data, 32'h10 + i);
            check("stream_last", out_last, i == 7);
        end
        req0_valid = 0;
        tick();
        check("stream_end", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_operand_arbiter.md
# alu_operand_arbiter

Two-requester arbiter and sequencer for the shared 32-bit operand path of the ALU. It drives the select of the 32-bit 2:1 operand mux and grants the path to one requester for a whole packet of beats. Accepted beats land in a one-entry output register with a valid/ready handshake toward the ALU issue stage. Each beat is tagged with the id of the requester that sent it.

## Interface
Parameters:
- WIDTH, 32, operand width; equals the shared mux width.

Ports:
- clock  in  1  single clock; all state changes on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 offers a beat.
- req0_data  in  WIDTH  requester 0 operand.
- req0_last  in  1  marks the final beat of requester 0's packet.
- req0_ready  out  1  requester 0 beat accepted this cycle when high with req0_valid.
- req1_valid, req1_data, req1_last, req1_ready  same as above, for requester 1.
- mux_sel  out  1  operand-mux select; 0 passes req0_data (in1), 1 passes req1_data (in2).
- out_valid  out  1  output register holds a beat.
- out_data  out  WIDTH  registered operand.
- out_id  out  1  requester id of out_data.
- out_last  out  1  registered last flag.
- out_ready  in  1  ALU issue stage consumes the beat when high with out_valid.

## Operation
- FSM states: IDLE (no owner), OWN0, OWN1. The current owner holds the path until its last beat is accepted.
- Grant in IDLE is combinational from req0_valid and req1_valid:
  - Only one valid: that requester wins.
  - Both valid: the arbitration policy decides (see Configuration).
  - The winner's first beat is accepted in the same cycle if there is space.
- space = !out_valid || out_ready. The output register holds one beat and can be refilled in the same cycle it drains.
- reqN_ready = (grantee == N) && space. grantee is the owner in OWN0/OWN1, or the IDLE winner.
- mux_sel = grantee. In IDLE with no valid request, mux_sel holds its last value.
- Transitions on an accepted beat:
  - last=0: move to or stay in OWN(grantee).
  - last=1: go to IDLE.
  - A single-beat packet (last=1 on the first beat) goes IDLE to IDLE and still updates the round-robin pointer.
- In OWNn, the other requester's valid is ignored and its ready stays 0, even if the owner deasserts valid mid-packet.
- Output register load: out_data, out_id, out_last are taken from the grantee's inputs through the mux.
- out_valid clears on out_ready only when no new beat is accepted in the same cycle.
- Requester data is never modified; no arithmetic is performed.

## Timing
- Reset (resetn=0, asynchronous), all outputs:
  - State IDLE.
  - out_valid=0, out_data=0, out_id=0, out_last=0.
  - mux_sel=0.
  - Round-robin pointer = 1, so requester 0 wins the first tie.
- Latency: a beat accepted at edge k is visible on out_* after edge k; out_valid is high in cycle k+1.
- Throughput: 1 beat/cycle while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, both readys are 0 and the registered outputs are stable.
- Reset mid-packet: ownership drops and any held beat is discarded. After release, arbitration restarts from the reset pointer.
- Boundary, last beat of OWN0 accepted while req1_valid=1: the next cycle is IDLE and req1 wins (RR), so there are no dead cycles beyond the IDLE grant.

## Configuration
- ALU_ARB_RR_EN defined: round-robin on ties.
  - The pointer records the last packet winner and updates when a packet's last beat is accepted.
  - On a tie, the requester that is not the pointer wins.
- ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins ties. The pointer logic is removed.

## Test plan
- Reset, then both valid with 1-beat packets (0xAAAA0000, 0x5555FFFF), out_ready=1 -> RR: out_id sequence 0,1,0,1; fixed: 0,0,… with requester 1 starved while req0 stays valid.
- Requester 0 sends a 3-beat packet (0x1,0x2,0x3, last on 0x3) with req1_valid=1 throughout -> req1_ready=0 for 3 cycles, mux_sel=0; then req1 is granted and mux_sel=1.
- OWN1 mid-packet, out_ready=0 for 4 cycles -> out_data stable, both readys 0; on out_ready=1, flow resumes with no beat lost or duplicated.
- Owner 0 deasserts req0_valid for 2 cycles mid-packet while req1_valid=1 -> no grant switch; packet completes when req0 resumes.
- resetn pulsed low asynchronously mid-packet with out_valid=1 -> out_valid=0 and mux_sel=0 immediately; after release, a tie goes to requester 0.
- Continuous streaming, out_ready=1, 8-beat packet 0x10..0x17 -> out_valid high for 8 consecutive cycles, data in order, out_last only on 0x17.
